verifier_w0_responder: RTL and testbench
========================================

VERIFIER_W0_RESPONDER -- requirements
Module: verifier_w0_responder

Interface
REQ-001 Parameter ngates, default 8: number of gates in the output layer.
REQ-002 Parameter ngbits, default $clog2(ngates): w0 length in words; overriding it to any other value SHALL be a elaboration error.
REQ-003 Parameter nabits, default max(1,$clog2(ngbits)): load address width; derived, not overridable.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rstb  in  1  synchronous, active-high reset.
REQ-006 load_en  in  1  write strobe for one w0 word from the verifier host.
REQ-007 load_addr  in  nabits  word index, 0..ngbits-1.
REQ-008 load_data  in  `F_NBITS  field element to store.
REQ-009 load_err  out  1  one-cycle pulse: a write was rejected.
REQ-010 loaded  out  1  all ngbits words written since the last clear.
REQ-011 req  in  1  request strobe from the layer-0 requester.
REQ-012 req_id  in  32  requester id, latched with the request.
REQ-013 req_err  out  1  one-cycle pulse: a request was rejected.
REQ-014 out_valid  out  1  out_data holds a valid word.
REQ-015 out_ready  in  1  requester accepts the word.
REQ-016 out_data  out  `F_NBITS  current w0 word.
REQ-017 out_idx  out  nabits  index of out_data.
REQ-018 out_last  out  1  out_idx == ngbits-1 while out_valid.
REQ-019 out_id  out  32  latched req_id, stable for the whole response.
REQ-020 done  out  1  one-cycle pulse after the last word transfers.

Function
REQ-021 The block SHALL hold a buffer of ngbits words plus a per-word written-flag vector; loaded = AND of the flags.
REQ-022 A write SHALL be accepted when load_en=1, load_addr<ngbits and state is IDLE: buffer[addr]<=load_data, flag[addr]<=1; rewriting a word SHALL overwrite it.
REQ-023 A write with load_addr>=ngbits, or any write outside IDLE, SHALL be discarded and SHALL pulse load_err the next cycle.
REQ-024 FSM states: IDLE, SEND, DONE.
REQ-025 IDLE->SEND when req=1 and loaded=1: latch out_id<=req_id and idx<=0.
REQ-026 In IDLE, req=1 with loaded=0 SHALL pulse req_err the next cycle and remain in IDLE.
REQ-027 In SEND, out_valid=1 and out_data=buffer[idx]; a transfer occurs on out_valid & out_ready.
REQ-028 On a transfer with idx<ngbits-1, idx<=idx+1; with idx=ngbits-1, the FSM SHALL go to DONE.
REQ-029 out_valid, out_data and out_idx SHALL hold steady while out_ready=0 (no bound on stall length).
REQ-030 DONE SHALL last one cycle with done=1, clear all written flags (each w0 set is single-use), then return to IDLE.
REQ-031 req=1 in SEND or DONE SHALL be ignored and SHALL pulse req_err the next cycle; out_id SHALL not change.
REQ-032 A write and a request in the same IDLE cycle: the write SHALL take effect and the request SHALL be evaluated against loaded before the write.
REQ-033 First-word latency SHALL be 1 cycle: req sampled at edge N gives out_valid=1 after edge N.
REQ-034 Minimum response duration SHALL be ngbits cycles in SEND plus 1 cycle in DONE.
REQ-035 Outside SEND, out_valid=0, out_last=0 and out_data=0.

Reset
REQ-036 With rstb=1 at a clock edge: state<=IDLE; all buffer words<=0; flags<=0; idx<=0; out_id<=0; outputs out_valid, out_last, done, load_err and req_err<=0; loaded<=0.
REQ-037 Reset asserted mid-SEND SHALL abort the response with no done pulse; the buffer SHALL be cleared.

Verification
REQ-038 ngates=8: write words 5,6,7 to addresses 0..2, then req with req_id=0x2A and out_ready=1 -> out_valid on the next cycle; data 5,6,7 on consecutive cycles with idx 0,1,2; out_last only with 7; out_id=0x2A; done pulses once; loaded=0 afterward.
REQ-039 req with only addresses 0 and 1 written -> req_err pulses once; out_valid stays 0; state remains IDLE.
REQ-040 During SEND, hold out_ready=0 for 4 cycles at idx=1, then pulse load_en and req -> word 1 stays stable; load_err and req_err each pulse once; the buffer and out_id are unchanged.
REQ-041 load_addr=3 with ngbits=3 -> load_err pulses and loaded stays 0; same-cycle write to address 2 and req with addresses 0 and 1 prefilled -> req_err pulses, then loaded=1.
REQ-042 Assert rstb during SEND at idx=1 -> the next cycle out_valid=0, done=0, loaded=0; a following req -> req_err.
REQ-043 ngates=2 (ngbits=1): load one word and req -> a single transfer with out_last=1 and idx=0, then done.

Source files
------------

// File: rtl/verifier_w0_responder.sv
// verifier_w0_responder: holds the w0 word set loaded by the verifier host
// and streams it once to the layer-0 requester over a valid/ready channel.
//
// Ports:
//   clk, rstb              clock, synchronous active-high reset
//   load_en/addr/data      host write of one w0 word
//   load_err               one-cycle pulse, a write was rejected
//   loaded                 every word written since the last clear
//   req, req_id            request strobe and requester id
//   req_err                one-cycle pulse, a request was rejected
//   out_valid/ready/data   response word handshake
//   out_idx, out_last      index of out_data, last-word marker
//   out_id                 latched requester id
//   done                   one-cycle pulse after the last transfer

`ifndef F_NBITS
`define F_NBITS 32
`endif

module verifier_w0_responder #(
    parameter int unsigned ngates = 8,
    parameter int unsigned ngbits = $clog2(ngates),
    localparam int unsigned nabits = (ngbits > 1) ? $clog2(ngbits) : 1
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                load_en,
    input  logic [nabits-1:0]   load_addr,
    input  logic [`F_NBITS-1:0] load_data,
    output logic                load_err,
    output logic                loaded,
    input  logic                req,
    input  logic [31:0]         req_id,
    output logic                req_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [`F_NBITS-1:0] out_data,
    output logic [nabits-1:0]   out_idx,
    output logic                out_last,
    output logic [31:0]         out_id,
    output logic                done
);

    // The word count is tied to the gate count; any override is rejected.
    if (ngbits != $clog2(ngates) || ngbits < 1) begin : g_bad_ngbits
        $error("verifier_w0_responder: ngbits must equal $clog2(ngates) and be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    localparam logic [nabits-1:0] last_idx = nabits'(ngbits - 1);

    state_t              state;
    logic [`F_NBITS-1:0] buffer [ngbits];
    logic [ngbits-1:0]   flags;
    logic [nabits-1:0]   idx;
    logic                addr_ok;
    logic                in_idle;

    assign addr_ok = 32'(load_addr) < ngbits;
    assign in_idle = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rstb) begin
            state    <= IDLE;
            flags    <= '0;
            idx      <= '0;
            out_id   <= '0;
            load_err <= 1'b0;
            req_err  <= 1'b0;
            for (int unsigned i = 0; i < ngbits; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            // Writes are only legal while idle; the buffer is frozen
            // for the whole response so out_data cannot change under it.
            load_err <= load_en && !(addr_ok && in_idle);
            // Request is judged on the flags as they stood before any
            // write landing in the same cycle.
            req_err  <= req && !(in_idle && loaded);

            if (load_en && addr_ok && in_idle) begin
                buffer[load_addr] <= load_data;
                flags[load_addr]  <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req && loaded) begin
                        state  <= SEND;
                        idx    <= '0;
                        out_id <= req_id;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx == last_idx) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // A w0 set is consumed by one response.
                    flags <= '0;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response outputs decode directly from the state/index flops.
    assign out_valid = (state == SEND);
    assign out_last  = out_valid && (idx == last_idx);
    assign out_data  = out_valid ? buffer[idx] : '0;
    assign out_idx   = idx;
    assign done      = (state == DONE);
    assign loaded    = &flags;

endmodule

// File: tb/tb_verifier_w0_responder.sv
// tb_verifier_w0_responder: directed and randomized checks of the w0
// responder for an 8-gate (3-word) and a 2-gate (1-word) instance.

`ifndef F_NBITS
`define F_NBITS 32
`endif

module tb_verifier_w0_responder;

    localparam int FW = `F_NBITS;

    logic clk = 1'b0;
    logic rstb = 1'b1;

    always #5 clk = ~clk;

    // 8 gates -> 3 words, 2-bit address
    logic          a_load_en = 1'b0;
    logic [1:0]    a_load_addr = '0;
    logic [FW-1:0] a_load_data = '0;
    logic          a_load_err;
    logic          a_loaded;
    logic          a_req = 1'b0;
    logic [31:0]   a_req_id = '0;
    logic          a_req_err;
    logic          a_out_valid;
    logic          a_out_ready = 1'b0;
    logic [FW-1:0] a_out_data;
    logic [1:0]    a_out_idx;
    logic          a_out_last;
    logic [31:0]   a_out_id;
    logic          a_done;

    // 2 gates -> 1 word, 1-bit address
    logic          b_load_en = 1'b0;
    logic [0:0]    b_load_addr = '0;
    logic [FW-1:0] b_load_data = '0;
    logic          b_load_err;
    logic          b_loaded;
    logic          b_req = 1'b0;
    logic [31:0]   b_req_id = '0;
    logic          b_req_err;
    logic          b_out_valid;
    logic          b_out_ready = 1'b0;
    logic [FW-1:0] b_out_data;
    logic [0:0]    b_out_idx;
    logic          b_out_last;
    logic [31:0]   b_out_id;
    logic          b_done;

    verifier_w0_responder #(.ngates(8)) dut_a (
        .clk       (clk),
        .rstb      (rstb),
        .load_en   (a_load_en),
        .load_addr (a_load_addr),
        .load_data (a_load_data),
        .load_err  (a_load_err),
        .loaded    (a_loaded),
        .req       (a_req),
        .req_id    (a_req_id),
        .req_err   (a_req_err),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_idx   (a_out_idx),
        .out_last  (a_out_last),
        .out_id    (a_out_id),
        .done      (a_done)
    );

    verifier_w0_responder #(.ngates(2)) dut_b (
        .clk       (clk),
        .rstb      (rstb),
        .load_en   (b_load_en),
        .load_addr (b_load_addr),
        .load_data (b_load_data),
        .load_err  (b_load_err),
        .loaded    (b_loaded),
        .req       (b_req),
        .req_id    (b_req_id),
        .req_err   (b_req_err),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_idx   (b_out_idx),
        .out_last  (b_out_last),
        .out_id    (b_out_id),
        .done      (b_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One host write to the 3-word instance; load_err is due one cycle later.
    task automatic a_write(input int addr, input logic [FW-1:0] d);
        a_load_en   = 1'b1;
        a_load_addr = addr[1:0];
        a_load_data = d;
        step();
        a_load_en   = 1'b0;
        chk("wr_load_err", a_load_err, (addr >= 3) ? 1 : 0);
    endtask

    // Reference model: the words last written since the set was consumed.
    logic [FW-1:0] m_mem [3];
    bit            m_flag [3];

    initial begin
        int unsigned id;
        int          nw;
        int          addr;
        logic [FW-1:0] d;
        bit          all;
        int          i;
        int          cyc;
        bit          rdy;

        // reset state
        rstb = 1'b1;
        step();
        step();
        rstb = 1'b0;
        chk("rst_valid",   a_out_valid, 0);
        chk("rst_loaded",  a_loaded, 0);
        chk("rst_done",    a_done, 0);
        chk("rst_load_err", a_load_err, 0);
        chk("rst_req_err", a_req_err, 0);
        chk("rst_data",    a_out_data, 0);
        chk("rst_last",    a_out_last, 0);
        chk("rst_out_id",  a_out_id, 0);
        chk("rst_b_valid", b_out_valid, 0);
        chk("rst_b_loaded", b_loaded, 0);

        // basic response
        a_write(0, 5);
        a_write(1, 6);
        a_write(2, 7);
        chk("basic_loaded", a_loaded, 1);
        a_req = 1'b1;
        a_req_id = 32'h2A;
        a_out_ready = 1'b1;
        step();
        a_req = 1'b0;
        chk("basic_req_err", a_req_err, 0);
        for (int k = 0; k < 3; k++) begin
            chk("basic_valid", a_out_valid, 1);
            chk("basic_data", a_out_data, 64'(5 + k));
            chk("basic_idx", a_out_idx, 64'(k));
            chk("basic_last", a_out_last, (k == 2) ? 1 : 0);
            chk("basic_id", a_out_id, 32'h2A);
            chk("basic_done_low", a_done, 0);
            step();
        end
        chk("basic_done", a_done, 1);
        chk("basic_end_valid", a_out_valid, 0);
        chk("basic_end_data", a_out_data, 0);
        step();
        chk("basic_done_once", a_done, 0);
        chk("basic_consumed", a_loaded, 0);
        a_out_ready = 1'b0;

        // request with a partial set
        a_write(0, 32'h10);
        a_write(1, 32'h11);
        a_req = 1'b1;
        a_req_id = 32'h99;
        step();
        a_req = 1'b0;
        chk("part_req_err", a_req_err, 1);
        chk("part_valid", a_out_valid, 0);
        step();
        chk("part_req_err_once", a_req_err, 0);
        chk("part_valid_idle", a_out_valid, 0);

        // stall plus illegal write and request during the response
        a_write(2, 32'h12);
        a_req = 1'b1;
        a_req_id = 32'h11;
        a_out_ready = 1'b1;
        step();
        a_req = 1'b0;
        chk("stall_idx0", a_out_idx, 0);
        step();
        a_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("stall_valid", a_out_valid, 1);
            chk("stall_idx", a_out_idx, 1);
            chk("stall_data", a_out_data, 32'h11);
            step();
        end
        a_load_en = 1'b1;
        a_load_addr = 2'd0;
        a_load_data = 32'h99;
        a_req = 1'b1;
        a_req_id = 32'h55;
        step();
        a_load_en = 1'b0;
        a_req = 1'b0;
        chk("busy_load_err", a_load_err, 1);
        chk("busy_req_err", a_req_err, 1);
        chk("busy_data", a_out_data, 32'h11);
        chk("busy_id", a_out_id, 32'h11);
        step();
        chk("busy_load_err_once", a_load_err, 0);
        chk("busy_req_err_once", a_req_err, 0);
        a_out_ready = 1'b1;
        step();
        chk("resume_idx", a_out_idx, 2);
        chk("resume_data", a_out_data, 32'h12);
        chk("resume_last", a_out_last, 1);
        step();
        chk("resume_done", a_done, 1);
        a_out_ready = 1'b0;
        step();

        // out-of-range write, then write racing a request
        a_write(3, 32'h33);
        chk("oor_loaded", a_loaded, 0);
        a_write(0, 32'h20);
        a_write(1, 32'h21);
        a_load_en = 1'b1;
        a_load_addr = 2'd2;
        a_load_data = 32'h22;
        a_req = 1'b1;
        a_req_id = 32'h44;
        step();
        a_load_en = 1'b0;
        a_req = 1'b0;
        chk("race_req_err", a_req_err, 1);
        chk("race_load_err", a_load_err, 0);
        chk("race_loaded", a_loaded, 1);
        chk("race_valid", a_out_valid, 0);

        // reset in the middle of a response
        a_req = 1'b1;
        a_req_id = 32'h77;
        a_out_ready = 1'b1;
        step();
        a_req = 1'b0;
        chk("abort_valid0", a_out_valid, 1);
        step();
        chk("abort_idx1", a_out_idx, 1);
        rstb = 1'b1;
        step();
        rstb = 1'b0;
        a_out_ready = 1'b0;
        chk("abort_valid", a_out_valid, 0);
        chk("abort_done", a_done, 0);
        chk("abort_loaded", a_loaded, 0);
        chk("abort_out_id", a_out_id, 0);
        a_req = 1'b1;
        step();
        a_req = 1'b0;
        chk("abort_req_err", a_req_err, 1);
        chk("abort_req_valid", a_out_valid, 0);
        step();

        // randomized rounds against the model (buffer cleared by reset)
        for (int k = 0; k < 3; k++) begin
            m_mem[k] = '0;
            m_flag[k] = 1'b0;
        end
        for (int r = 0; r < 30; r++) begin
            nw = $urandom_range(0, 5);
            for (int w = 0; w < nw; w++) begin
                addr = $urandom_range(0, 3);
                d = FW'($urandom);
                a_write(addr, d);
                if (addr < 3) begin
                    m_mem[addr] = d;
                    m_flag[addr] = 1'b1;
                end
            end
            all = m_flag[0] && m_flag[1] && m_flag[2];
            chk("rnd_loaded", a_loaded, all);
            id = $urandom;
            a_req = 1'b1;
            a_req_id = id;
            step();
            a_req = 1'b0;
            chk("rnd_req_err", a_req_err, !all);
            if (!all) begin
                chk("rnd_idle_valid", a_out_valid, 0);
            end else begin
                i = 0;
                cyc = 0;
                while (i < 3 && cyc < 200) begin
                    chk("rnd_valid", a_out_valid, 1);
                    chk("rnd_data", a_out_data, m_mem[i]);
                    chk("rnd_idx", a_out_idx, 64'(i));
                    chk("rnd_last", a_out_last, (i == 2) ? 1 : 0);
                    chk("rnd_id", a_out_id, id);
                    rdy = 1'($urandom % 2);
                    a_out_ready = rdy;
                    step();
                    if (rdy) i++;
                    cyc++;
                end
                a_out_ready = 1'b0;
                chk("rnd_transfers", i, 3);
                chk("rnd_done", a_done, 1);
                chk("rnd_done_valid", a_out_valid, 0);
                step();
                chk("rnd_done_once", a_done, 0);
                chk("rnd_consumed", a_loaded, 0);
                for (int k = 0; k < 3; k++) m_flag[k] = 1'b0;
            end
        end

        // single-word instance
        b_load_en = 1'b1;
        b_load_addr = 1'b0;
        b_load_data = 32'hABC;
        step();
        b_load_en = 1'b0;
        chk("b_loaded", b_loaded, 1);
        b_req = 1'b1;
        b_req_id = 32'h3;
        step();
        b_req = 1'b0;
        chk("b_valid", b_out_valid, 1);
        chk("b_idx", b_out_idx, 0);
        chk("b_last", b_out_last, 1);
        chk("b_data", b_out_data, 32'hABC);
        chk("b_id", b_out_id, 32'h3);
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        chk("b_done", b_done, 1);
        chk("b_end_valid", b_out_valid, 0);
        step();
        chk("b_done_once", b_done, 0);
        chk("b_consumed", b_loaded, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
